// File: rtl/uart_pkg.sv
// Shared UART constants: default clock/line rates, bit-period computation,
// frame length and the FSM state encodings used by the RX and TX halves.
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEF  = 50_000_000;
    localparam int unsigned BAUD_RATE_DEF = 9600;
    localparam int unsigned FRAME_BITS    = 10;

    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop sync + edge detect, mid-bit sampling, rx_done one-clock pulse.
// Latency: rx_done one clock after the stop-bit sample; no backpressure, consumer must take the byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ_DEF, BAUD_RATE_DEF)
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_done
);

    localparam int unsigned      CNT_W    = $clog2(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MAX / 2);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    rx_state_t        state, state_nxt;
    logic             rx_s1, rx_s2, rx_s3;
    logic             fall, sample, cnt_wrap, done_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift_reg;

    assign fall     = rx_s3 && !rx_s2;
    assign sample   = (state == RX_BUSY) && (baud_cnt == CNT_MID);
    assign cnt_wrap = (baud_cnt == CNT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Returning to idle at the stop-bit midpoint lets a back-to-back start edge be seen.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall) state_nxt = RX_BUSY;
            end
            RX_BUSY: begin
                if (sample) begin
                    if (bit_idx == 4'd0 && rx_s2) begin
                        state_nxt = RX_IDLE;
                    end else if (bit_idx == LAST_BIT) begin
                        state_nxt = RX_IDLE;
                        done_nxt  = rx_s2;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_s3     <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
        end else begin
            rx_s1   <= rs232_rx;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            rx_done <= done_nxt;
            if (done_nxt) rx_data <= shift_reg;
            if (state == RX_BUSY && state_nxt == RX_BUSY) begin
                if (cnt_wrap) begin
                    baud_cnt <= '0;
                    bit_idx  <= bit_idx + 4'd1;
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end else begin
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
            if (sample && bit_idx != 4'd0 && bit_idx != LAST_BIT) begin
                shift_reg <= {rx_s2, shift_reg[7:1]};
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: registered line output, each bit exactly BAUD_CNT_MAX clocks.
// Latency: start bit on the clock after tx_start; tx_start ignored while tx_busy (caller holds data).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ_DEF, BAUD_RATE_DEF)
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx
);

    localparam int unsigned      CNT_W    = $clog2(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    tx_state_t        state, state_nxt;
    logic             tx_nxt, cnt_wrap;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift_reg;

    assign tx_busy  = (state == TX_SEND);
    assign cnt_wrap = (baud_cnt == CNT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tx_nxt is the level for the bit that begins at the next edge.
    always_comb begin
        state_nxt = state;
        tx_nxt    = tx;
        case (state)
            TX_IDLE: begin
                tx_nxt = 1'b1;
                if (tx_start) begin
                    state_nxt = TX_SEND;
                    tx_nxt    = 1'b0;
                end
            end
            TX_SEND: begin
                if (cnt_wrap) begin
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = TX_IDLE;
                        tx_nxt    = 1'b1;
                    end else if (bit_idx == LAST_BIT - 4'd1) begin
                        tx_nxt = 1'b1;
                    end else begin
                        tx_nxt = shift_reg[bit_idx[2:0]];
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            tx <= tx_nxt;
            if (state == TX_IDLE && tx_start) shift_reg <= tx_data;
            if (state == TX_SEND && state_nxt == TX_SEND) begin
                if (cnt_wrap) begin
                    baud_cnt <= '0;
                    bit_idx  <= bit_idx + 4'd1;
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end else begin
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
        end
    end

endmodule

// File: rtl/uart_top.sv
// UART echo: received bytes are retransmitted, with a one-byte holder while TX is busy.
// Latency: TX start bit two clocks after the RX stop-bit sample; newest byte overwrites a full holder.
module uart_top
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
    parameter int unsigned BAUD_RATE = BAUD_RATE_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rs232_rx,
    output logic rs232_tx
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD_RATE);

    logic [7:0] rx_data, tx_data, hold_dat;
    logic       rx_done, tx_start, tx_busy, hold_vld;
    logic       send_hold, send_direct;

    // The holder drains before a fresh byte may bypass it, keeping echo order intact.
    assign send_hold   = hold_vld && !tx_busy;
    assign send_direct = rx_done && !tx_busy && !hold_vld;
    assign tx_start    = send_hold || send_direct;
    assign tx_data     = send_hold ? hold_dat : rx_data;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_dat <= '0;
            hold_vld <= 1'b0;
        end else if (rx_done && !send_direct) begin
            hold_dat <= rx_data;
            hold_vld <= 1'b1;
        end else if (send_hold) begin
            hold_vld <= 1'b0;
        end
    end

    uart_rx #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_rx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done)
    );

    uart_tx #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx        (rs232_tx)
    );

endmodule

// File: tb/tb_uart_top.sv
// Directed echo bench; line rate raised so one bit is 32 clocks, keeping runs short.
module tb_uart_top;

    localparam int BIT = 32;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         start;
    } frame_t;

    logic   sys_clk = 1'b0;
    logic   sys_rst_n;
    logic   rs232_rx;
    logic   rs232_tx;

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     tx_low_cnt = 0;
    int     done_cnt = 0;
    int     last_stop_mid = 0;
    frame_t frames[$];

    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    int         mon_start = 0;
    logic [7:0] mon_sh = '0;

    uart_top #(.CLK_FREQ(50_000_000), .BAUD_RATE(1_562_500)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rs232_rx  (rs232_rx),
        .rs232_tx  (rs232_tx)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (dut.rx_done === 1'b1) done_cnt = done_cnt + 1;
    end

    // Line decoder for rs232_tx, sampling each bit at its centre.
    always @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mon_busy = 1'b0;
            mon_cnt  = 0;
        end else if (!mon_busy) begin
            if (rs232_tx === 1'b0) begin
                tx_low_cnt = tx_low_cnt + 1;
                mon_busy   = 1'b1;
                mon_cnt    = 0;
                mon_start  = cyc;
            end
        end else begin
            if (rs232_tx === 1'b0) tx_low_cnt = tx_low_cnt + 1;
            mon_cnt = mon_cnt + 1;
            if (mon_cnt % BIT == BIT / 2) begin
                if (mon_cnt / BIT == 0) begin
                    if (rs232_tx !== 1'b0) mon_busy = 1'b0;
                end else if (mon_cnt / BIT <= 8) begin
                    mon_sh[mon_cnt / BIT - 1] = rs232_tx;
                end else begin
                    frames.push_back('{d: mon_sh, stop: rs232_tx, start: mon_start});
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rs232_rx = b;
        repeat (BIT) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        last_stop_mid = cyc + BIT / 2;
        drive_bit(stop);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pop(output logic [7:0] d, output logic s, output int st);
        frame_t f;
        if (frames.size() > 0) begin
            f  = frames.pop_front();
            d  = f.d;
            s  = f.stop;
            st = f.start;
        end else begin
            d  = 'x;
            s  = 1'bx;
            st = -100000;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       s;
        int         st;
        int         delta;
        int         done_base;
        int         k;

        sys_rst_n = 1'b0;
        rs232_rx  = 1'b1;
        settle(5);
        check("reset_tx_high", rs232_tx, 1);
        check("reset_rx_done_low", dut.rx_done, 0);
        sys_rst_n = 1'b1;

        settle(2000);
        check("idle_tx_never_low", tx_low_cnt, 0);
        check("idle_no_rx_done", done_cnt, 0);

        send_byte(8'h00, 1'b1);
        drive_bit(1'b1);
        settle(12 * BIT);
        check("single_frame_count", frames.size(), 1);
        pop(d, s, st);
        check("single_data_00", d, 8'h00);
        check("single_stop_bit", s, 1);
        delta = st - last_stop_mid;
        check("single_start_latency_window", (delta >= 1 && delta <= 8), 1);

        for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1);
        rs232_rx = 1'b1;
        settle(12 * BIT);
        check("b2b_frame_count", frames.size(), 8);
        for (int i = 0; i < 8; i++) begin
            pop(d, s, st);
            check($sformatf("b2b_data_%0d", i), {s, d}, {1'b1, 8'(i)});
        end

        done_base = done_cnt;
        send_byte(8'hA5, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_byte(8'h3C, 1'b1);
        drive_bit(1'b1);
        settle(12 * BIT);
        check("frame_err_rx_done_count", done_cnt - done_base, 1);
        check("frame_err_echo_count", frames.size(), 1);
        pop(d, s, st);
        check("frame_err_next_data_3c", d, 8'h3C);

        done_base = done_cnt;
        rs232_rx = 1'b0;
        settle(8);
        rs232_rx = 1'b1;
        settle(15 * BIT);
        check("glitch_no_rx_done", done_cnt - done_base, 0);
        check("glitch_no_echo", frames.size(), 0);

        send_byte(8'h55, 1'b1);
        rs232_rx = 1'b1;
        k = 0;
        while (rs232_tx !== 1'b0 && k < 4 * BIT) begin
            @(negedge sys_clk);
            k++;
        end
        check("mid_echo_tx_low_before_reset", rs232_tx, 0);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("reset_async_tx_high", rs232_tx, 1);
        settle(10);
        sys_rst_n = 1'b1;
        settle(12 * BIT);
        check("reset_aborted_echo", frames.size(), 0);

        send_byte(8'h5A, 1'b1);
        drive_bit(1'b1);
        settle(12 * BIT);
        check("post_reset_frame_count", frames.size(), 1);
        pop(d, s, st);
        check("post_reset_data_5a", {s, d}, {1'b1, 8'h5A});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-002 BAUD_RATE, default 9600, line rate in bit/s; BAUD_CNT_MAX = CLK_FREQ/BAUD_RATE (integer division) = 5208 clocks per bit at defaults.
REQ-003 sys_clk  input  1  single system clock, all logic on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rs232_rx  input  1  asynchronous serial input, idle high.
REQ-006 rs232_tx  output  1  serial output, idle high.

Function
REQ-007 Block SHALL be a UART echo: every correctly framed byte received on rs232_rx SHALL be retransmitted unchanged on rs232_tx.
REQ-008 Frame SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit BAUD_CNT_MAX clocks.
REQ-009 rs232_rx SHALL pass a 2-flop synchronizer; a third flop provides falling-edge detection.
REQ-010 RX idle: a synchronized falling edge SHALL start a frame; edges while a frame is in progress SHALL be ignored.
REQ-011 RX SHALL use a baud counter 0..BAUD_CNT_MAX-1 and a bit index 0..9; each bit SHALL be sampled when counter = BAUD_CNT_MAX/2 (2604).
REQ-012 Start bit sampled as 1 SHALL abort the frame and return to idle (glitch rejection).
REQ-013 Data bits SHALL shift into an 8-bit register, bit 0 first.
REQ-014 At stop-bit sample: if 1, RX SHALL present the byte and pulse rx_done high for exactly one clock; if 0 (framing error), byte SHALL be discarded, no pulse; RX SHALL return to idle immediately after the stop-bit sample so back-to-back frames are accepted.
REQ-015 TX SHALL start the start bit on the clock after rx_done when idle; each bit lasts exactly BAUD_CNT_MAX clocks; busy clears at the end of the full stop bit.
REQ-016 A one-byte holding register SHALL capture rx_done data when TX is busy; TX SHALL send it on the clock after busy clears; if the holder is already full, the newer byte SHALL overwrite it.
REQ-017 rs232_tx SHALL be driven from a flop (no combinational glitches).

Reset
REQ-018 While sys_rst_n = 0: rs232_tx = 1, all counters/bit indices = 0, RX/TX idle, holding register empty, rx_done = 0, synchronizer flops = 1.
REQ-019 Reset mid-frame SHALL abort both directions immediately; after release the block SHALL wait for a new falling edge.

Structure
REQ-020 A shared package SHALL hold CLK_FREQ/BAUD_RATE defaults, BAUD_CNT_MAX computation, and the frame-bit-count constant (10).
REQ-021 uart_top SHALL instantiate two sub-modules, uart_rx (outputs rx_data[7:0], rx_done) and uart_tx (inputs tx_data[7:0], tx_start; output tx_busy, tx); the holding register lives in uart_top.
REQ-022 Total RTL 120-400 lines.

Verification
REQ-023 Reset, rs232_rx held 1 for 10 ms -> rs232_tx constantly 1, no rx_done.
REQ-024 Single byte 8'h00 at 104160 ns/bit -> rs232_tx outputs start, eight 0s, stop; start edge within 2610 clocks + 5 of the RX stop-bit midpoint.
REQ-025 Back-to-back bytes 8'h00..8'h07, 5208 clocks per bit, no idle gap -> eight echoed frames in order with matching data, none lost.
REQ-026 Frame 8'hA5 with stop bit forced 0 -> no echo; following 8'h3C -> echoed 8'h3C.
REQ-027 0 pulse of 100 clocks on rs232_rx -> rejected as false start, no echo.
REQ-028 sys_rst_n low for 10 clocks mid-echo of 8'h55 -> rs232_tx returns 1 asynchronously; next byte 8'h5A echoes correctly.
